// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle main controller.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_SW   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] PC_INC = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

endpackage

// File: rtl/mc_decode.sv
// IR field extraction and instruction class decode.
module mc_decode
  import mc_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [15:0] imm,
  output logic [2:0]  alu_fn,
  output logic        use_imm,
  output logic        is_rtype,
  output logic        is_addi,
  output logic        is_lw,
  output logic        is_sw,
  output logic        is_mem,
  output logic        is_branch,
  output logic        is_jmp,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [3:0] op;

  assign op  = ir[15:12];
  assign rd  = ir[11:8];
  assign rs  = ir[7:4];
  assign rt  = ir[3:0];
  assign imm = sext4(ir[3:0]);

  assign is_rtype   = ~op[3];
  assign is_addi    = (op == OP_ADDI);
  assign is_lw      = (op == OP_LW);
  assign is_sw      = (op == OP_SW);
  assign is_mem     = is_lw | is_sw;
  assign is_branch  = (op == OP_BEQ);
  assign is_jmp     = (op == OP_JMP);
  assign is_halt    = (op == OP_HALT);
  assign is_illegal = (op == 4'hD) | (op == 4'hE);
  assign use_imm    = is_addi | is_mem;

  // BEQ compares by subtraction; address and ADDI math are adds.
  always_comb begin
    alu_fn = ALU_ADD;
    if (is_rtype)
      alu_fn = op[2:0];
    else if (is_branch)
      alu_fn = ALU_SUB;
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle main controller: IR, state sequencing and datapath controls.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        mem_rdy,
  input  logic        alu_zero,
  output logic [3:0]  read1,
  output logic [3:0]  read2,
  output logic [3:0]  read3,
  output logic [3:0]  rwr,
  output logic        wen,
  output logic        wb_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [15:0] imm,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        halted,
  output logic        illegal
);

  state_t      state;
  logic [15:0] ir;
  logic [3:0]  f_rd, f_rs, f_rt;
  logic [15:0] f_imm;
  logic [2:0]  alu_fn;
  logic        use_imm;
  logic        is_rtype, is_addi, is_lw, is_sw, is_mem;
  logic        is_branch, is_jmp, is_halt, is_illegal;
  logic        live;

  mc_decode u_dec (
    .ir         (ir),
    .rd         (f_rd),
    .rs         (f_rs),
    .rt         (f_rt),
    .imm        (f_imm),
    .alu_fn     (alu_fn),
    .use_imm    (use_imm),
    .is_rtype   (is_rtype),
    .is_addi    (is_addi),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_mem     (is_mem),
    .is_branch  (is_branch),
    .is_jmp     (is_jmp),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH:
          if (mem_rdy) begin
            ir    <= instr;
            state <= S_DECODE;
          end
        S_DECODE:
          if (is_halt)         state <= S_HALT;
          else if (is_illegal) state <= S_FETCH;
          else                 state <= S_EXEC;
        S_EXEC:
          if (is_rtype || is_addi) state <= S_WB;
          else if (is_mem)         state <= S_MEM;
          else                     state <= S_FETCH;
        S_MEM:
          if (mem_rdy) state <= is_lw ? S_WB : S_FETCH;
        S_WB:   state <= S_FETCH;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register-file addresses and imm are silenced only in IDLE and HALT.
  assign live = (state != S_IDLE) && (state != S_HALT);

  always_comb begin
    read1       = live ? f_rs  : '0;
    read2       = live ? f_rt  : '0;
    read3       = live ? f_rd  : '0;
    rwr         = live ? f_rd  : '0;
    imm         = live ? f_imm : '0;
    wen         = 1'b0;
    wb_sel      = 1'b0;
    alu_op      = '0;
    alu_src_imm = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    ir_load     = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    halted      = 1'b0;
    illegal     = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_INC;
        end
      end
      S_DECODE: illegal = is_illegal;
      S_EXEC: begin
        alu_op      = alu_fn;
        alu_src_imm = use_imm;
        if (is_branch) begin
          pc_write = alu_zero;
          pc_src   = PC_BR;
        end else if (is_jmp) begin
          pc_write = 1'b1;
          pc_src   = PC_JMP;
        end
      end
      S_MEM: begin
        mem_rd = is_lw;
        mem_wr = is_sw;
        wb_sel = is_lw;
      end
      S_WB: begin
        wen    = 1'b1;
        wb_sel = is_lw;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with hand-computed expectations.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        mem_rdy;
  logic        alu_zero;
  logic [3:0]  read1, read2, read3, rwr;
  logic        wen, wb_sel, alu_src_imm;
  logic [2:0]  alu_op;
  logic [15:0] imm;
  logic        mem_rd, mem_wr, ir_load, pc_write;
  logic [1:0]  pc_src;
  logic        halted, illegal;
  logic [45:0] all_o;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .mem_rdy     (mem_rdy),
    .alu_zero    (alu_zero),
    .read1       (read1),
    .read2       (read2),
    .read3       (read3),
    .rwr         (rwr),
    .wen         (wen),
    .wb_sel      (wb_sel),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .imm         (imm),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .ir_load     (ir_load),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .halted      (halted),
    .illegal     (illegal)
  );

  assign all_o = {read1, read2, read3, rwr, wen, wb_sel, alu_op,
                  alu_src_imm, imm, mem_rd, mem_wr, ir_load,
                  pc_write, pc_src, halted, illegal};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic nxt(input logic [15:0] i, input logic r,
                     input logic z);
    @(negedge clk);
    instr    = i;
    mem_rdy  = r;
    alu_zero = z;
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = '0; mem_rdy = 1'b1; alu_zero = 1'b0;
    #12;
    check("rst_all0", all_o, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("idle_mrd", mem_rd, 0);

    // ADD r3 = r1 + r2
    nxt(16'h0312, 1, 0);
    check("add_f_mrd", mem_rd, 1);
    check("add_f_ld", ir_load, 1);
    check("add_f_pcw", pc_write, 1);
    check("add_f_pcs", pc_src, 0);
    nxt(16'h0312, 1, 0);
    check("add_d_r1", read1, 1);
    check("add_d_r2", read2, 2);
    check("add_d_rwr", rwr, 3);
    check("add_d_wen", wen, 0);
    nxt(16'h0312, 1, 0);
    check("add_e_op", alu_op, 0);
    check("add_e_src", alu_src_imm, 0);
    check("add_e_wen", wen, 0);
    nxt(16'h0312, 1, 0);
    check("add_w_wen", wen, 1);
    check("add_w_sel", wb_sel, 0);

    // LW r10 = mem[r4 + -1], two wait cycles
    nxt(16'h9A4F, 1, 0);
    check("add_next_ld", ir_load, 1);
    check("lw_f_wen", wen, 0);
    nxt(16'h9A4F, 1, 0);
    check("lw_d_imm", imm, 16'hFFFF);
    check("lw_d_r1", read1, 4);
    nxt(16'h9A4F, 1, 0);
    check("lw_e_src", alu_src_imm, 1);
    check("lw_e_op", alu_op, 0);
    nxt(16'h9A4F, 0, 0);
    check("lw_m1_rd", mem_rd, 1);
    nxt(16'h9A4F, 0, 0);
    check("lw_m2_rd", mem_rd, 1);
    nxt(16'h9A4F, 1, 0);
    check("lw_m3_rd", mem_rd, 1);
    check("lw_m3_wen", wen, 0);
    nxt(16'h9A4F, 1, 0);
    check("lw_w_wen", wen, 1);
    check("lw_w_rwr", rwr, 4'hA);
    check("lw_w_sel", wb_sel, 1);
    check("lw_w_mrd", mem_rd, 0);

    // BEQ taken
    nxt(16'hB12E, 1, 1);
    check("beq1_f_ld", ir_load, 1);
    nxt(16'hB12E, 1, 1);
    check("beq1_d_imm", imm, 16'hFFFE);
    check("beq1_d_r3", read3, 1);
    check("beq1_d_r1", read1, 2);
    nxt(16'hB12E, 1, 1);
    check("beq1_e_pcw", pc_write, 1);
    check("beq1_e_pcs", pc_src, 1);
    check("beq1_e_op", alu_op, 1);
    check("beq1_e_wen", wen, 0);

    // BEQ not taken
    nxt(16'hB12E, 1, 0);
    check("beq2_f_ld", ir_load, 1);
    nxt(16'hB12E, 1, 0);
    nxt(16'hB12E, 1, 0);
    check("beq2_e_pcw", pc_write, 0);
    check("beq2_e_pcs", pc_src, 1);

    // illegal opcode 0xD
    nxt(16'hD123, 1, 0);
    check("ill_f_ld", ir_load, 1);
    nxt(16'hD123, 1, 0);
    check("ill_d_pulse", illegal, 1);

    // SW mem[r3 + 1] = r5
    nxt(16'hA531, 1, 0);
    check("ill_back_f", mem_rd, 1);
    check("ill_clear", illegal, 0);
    nxt(16'hA531, 1, 0);
    check("sw_d_r3", read3, 5);
    nxt(16'hA531, 1, 0);
    check("sw_e_src", alu_src_imm, 1);
    nxt(16'hA531, 1, 0);
    check("sw_m_wr", mem_wr, 1);
    check("sw_m_rd", mem_rd, 0);

    // JMP
    nxt(16'hC123, 1, 0);
    check("jmp_f_ld", ir_load, 1);
    nxt(16'hC123, 1, 0);
    nxt(16'hC123, 1, 0);
    check("jmp_e_pcw", pc_write, 1);
    check("jmp_e_pcs", pc_src, 2);

    // FETCH stall of 5 cycles
    for (int i = 0; i < 5; i++) begin
      nxt(16'hF000, 0, 0);
      check("stall_mrd", mem_rd, 1);
      check("stall_ld", ir_load, 0);
      check("stall_pcw", pc_write, 0);
    end

    // HALT
    nxt(16'hF000, 1, 0);
    check("hlt_f_ld", ir_load, 1);
    nxt(16'h0000, 1, 0);
    check("hlt_d_hl", halted, 0);
    for (int i = 0; i < 20; i++) begin
      nxt(16'h0312, 1, 0);
      check("hlt_hold", halted, 1);
    end
    check("hlt_others", all_o, 46'h2);
    #2 rst = 1'b1; #1;
    check("hlt_rst_async", halted, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rst2_idle", all_o, 0);

    // reset during WB cancels the write
    nxt(16'h0312, 1, 0);
    check("rst2_fetch", mem_rd, 1);
    nxt(16'h0312, 1, 0);
    nxt(16'h0312, 1, 0);
    check("wbr_e_wen", wen, 0);
    @(posedge clk); #2;
    check("wbr_wen_hi", wen, 1);
    rst = 1'b1; #1;
    check("wbr_wen_drop", wen, 0);
    @(negedge clk); #1;
    check("wbr_negedge", all_o, 0);
    rst = 1'b0;
    nxt(16'h0312, 1, 0);
    check("wbr_fetch", mem_rd, 1);
    check("wbr_fetch_wen", wen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
